// File: rtl/fifo_arb_pkg.sv
// Shared types and the rotate-priority search used by the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req_vec scanning ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int unsigned        n);
    rr_pick_t         p;
    logic [IDX_W-1:0] j;
    p = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = IDX_W'((32'(ptr) + k) % n);
      if (k < n && !p.found && req_vec[j]) begin
        p.found = 1'b1;
        p.idx   = j;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_sel.sv
// Rotate-priority encoder: lowest-offset set request starting at ptr.
// Purely combinational, no latency, no backpressure.
module rr_prio_sel
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               found
);

  rr_pick_t pick;

  always_comb pick = rr_pick(MAX_REQ'(req_vec), IDX_W'(ptr), NUM_REQ);

  assign found  = pick.found;
  assign idx    = pick.idx[IW-1:0];
  assign onehot = found ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst-locking arbiter sharing one async-FIFO write port; 1 cycle gnt->winc.
// winc is gated combinationally by wfull; while the output word is held no new grant is issued.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_BURST  = 4,
  localparam int IW         = $clog2(NUM_REQ),
  localparam int BW         = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_en,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [IW-1:0]                 owner,
  output logic                          busy,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata
);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BURST_CAP = BW'(MAX_BURST);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  out_vld_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    sel_oh;
  logic [IW-1:0]         sel_idx;
  logic                  sel_found;
  logic                  can_accept;
  logic                  accept;
  logic [IW-1:0]         acc_idx;
  logic [DATA_WIDTH-1:0] acc_data;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  assign elig       = req & req_en;
  assign winc       = out_vld_q & ~wfull;
  assign can_accept = ~out_vld_q | winc;
  assign acc_data   = req_data[acc_idx*DATA_WIDTH +: DATA_WIDTH];

  rr_prio_sel #(.NUM_REQ(NUM_REQ)) u_sel (
    .req_vec (elig),
    .ptr     (rr_ptr_q),
    .onehot  (sel_oh),
    .idx     (sel_idx),
    .found   (sel_found)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    gnt      = '0;
    accept   = 1'b0;
    acc_idx  = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (can_accept && sel_found && !wrst) begin
          accept  = 1'b1;
          gnt     = sel_oh;
          acc_idx = sel_idx;
          owner_d = sel_idx;
          if (MAX_BURST > 1) begin
            state_d = ARB_OWN;
            beat_d  = BW'(1);
          end else begin
            rr_ptr_d = next_idx(sel_idx);
            beat_d   = '0;
          end
        end
      end
      ARB_OWN: begin
        // Lock drops when the owner goes away or has used its full burst; no grant that cycle.
        if (!elig[owner_q] || beat_q == BURST_CAP) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = next_idx(owner_q);
          beat_d   = '0;
        end else if (can_accept && !wrst) begin
          accept       = 1'b1;
          gnt[owner_q] = 1'b1;
          beat_d       = beat_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (accept) begin
      out_vld_q  <= 1'b1;
      out_data_q <= acc_data;
    end else begin
      out_vld_q  <= out_vld_q & ~winc;
    end
  end

  assign busy  = (state_q == ARB_OWN);
  assign owner = owner_q;
  assign wdata = out_data_q;

endmodule
